// File: rtl/wb_slave_mux.sv
// -----------------------------------------------------------------------------
// wb_slave_mux
//
// Single-master to four-slave Wishbone address decoder and response mux.
// A master request is latched in IDLE and decoded against four base/width
// windows, with the lowest slave index winning on overlap. The latched request
// is then presented to the selected slave while the FSM sits in WAIT. The
// slave's ack or err is returned to the master as a one-cycle registered
// response in RESP. Unmapped addresses get an immediate error response, and
// error responses return DEFAULT_READ_VALUE as read data.
//
// Optional feature (macro WB_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter ends a transfer with an error and a
//   timeout_o pulse after TIMEOUT_CYCLES silent cycles. When undefined, no
//   counter exists, WAIT lasts until ack/err/cycle drop, and timeout_o is 0.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   m_adr_i .. m_cyc_i     master request (address, data, we, sel, stb, cyc)
//   m_dat_o                registered read data to master
//   m_ack_o, m_err_o       registered one-cycle acknowledge / error
//   s_adr_o .. s_we_o      latched request towards the slaves
//   s_cyc_o                cycle, high while a slave access is in flight
//   s_stb_o[3:0]           one-hot strobe of the selected slave
//   s_dat_i[127:0]         slave read data, slave n on [32n+31:32n]
//   s_ack_i, s_err_i       per-slave acknowledge / error
//   timeout_o              one-cycle timeout pulse (aligned with m_err_o)
// -----------------------------------------------------------------------------
module wb_slave_mux #(
  parameter logic [31:0] S0_BASE            = 32'h8000_0000,
  parameter int unsigned S0_AW              = 27,
  parameter logic [31:0] S1_BASE            = 32'hF000_0000,
  parameter int unsigned S1_AW              = 11,
  parameter logic [31:0] S2_BASE            = 32'hF000_0800,
  parameter int unsigned S2_AW              = 11,
  parameter logic [31:0] S3_BASE            = 32'hF800_0000,
  parameter int unsigned S3_AW              = 14,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADF_ABAC
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  // master side
  input  logic [31:0]   m_adr_i,
  input  logic [31:0]   m_dat_i,
  input  logic          m_we_i,
  input  logic [3:0]    m_sel_i,
  input  logic          m_stb_i,
  input  logic          m_cyc_i,
  output logic [31:0]   m_dat_o,
  output logic          m_ack_o,
  output logic          m_err_o,
  // slave side
  output logic [31:0]   s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic [3:0]    s_stb_o,
  input  logic [127:0]  s_dat_i,
  input  logic [3:0]    s_ack_i,
  input  logic [3:0]    s_err_i,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q,  adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q,  sel_d;
  logic        we_q,   we_d;
  logic [1:0]  idx_q,  idx_d;
  logic [31:0] rdat_q, rdat_d;
  logic        ack_q,  ack_d;
  logic        err_q,  err_d;

  // ---------------------------------------------------------------------------
  // Address decode: compare only the bits above each slave's window width.
  // ---------------------------------------------------------------------------
  logic [3:0] hit;
  logic [1:0] hit_idx;
  logic       any_hit;

  assign hit[0] = (m_adr_i >> S0_AW) == (S0_BASE >> S0_AW);
  assign hit[1] = (m_adr_i >> S1_AW) == (S1_BASE >> S1_AW);
  assign hit[2] = (m_adr_i >> S2_AW) == (S2_BASE >> S2_AW);
  assign hit[3] = (m_adr_i >> S3_AW) == (S3_BASE >> S3_AW);
  assign any_hit = |hit;

  // Overlapping windows resolve to the lowest index.
  always_comb begin
    hit_idx = 2'd0;
    if      (hit[0]) hit_idx = 2'd0;
    else if (hit[1]) hit_idx = 2'd1;
    else if (hit[2]) hit_idx = 2'd2;
    else if (hit[3]) hit_idx = 2'd3;
  end

  // Only the latched slave's handshake is looked at; everything else is noise.
  logic sel_ack;
  logic sel_err;
  assign sel_ack = s_ack_i[idx_q];
  assign sel_err = s_err_i[idx_q];

  // ---------------------------------------------------------------------------
  // Optional WAIT timeout
  // ---------------------------------------------------------------------------
  logic tmo_hit;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // cnt_q counts completed WAIT cycles, so the current cycle is the last
  // allowed one when cnt_q reaches TIMEOUT_CYCLES-1.
  assign tmo_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
    // The timeout only fires when nothing else ends the transfer this cycle.
    tmo_d = tmo_hit && m_cyc_i && !sel_err && !sel_ack;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    idx_d   = idx_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d  = m_adr_i;
          wdat_d = m_dat_i;
          sel_d  = m_sel_i;
          we_d   = m_we_i;
          idx_d  = hit_idx;
          if (any_hit) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdat_d  = DEFAULT_READ_VALUE;
          end
        end
      end

      ST_WAIT: begin
        if (!m_cyc_i) begin
          // Master abandoned the cycle: silently return, no response.
          state_d = ST_IDLE;
        end else if (sel_err) begin
          // err outranks a simultaneous ack.
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdat_d  = DEFAULT_READ_VALUE;
        end else if (sel_ack) begin
          // An ack on the expiry cycle still wins over the timeout.
          state_d = ST_RESP;
          ack_d   = 1'b1;
          rdat_d  = s_dat_i[{idx_q, 5'd0} +: 32];
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdat_d  = DEFAULT_READ_VALUE;
        end
      end

      // Response is on the outputs this cycle; any request now is not taken.
      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the latched request registers are reset as well, so the slave
      // bus shows zeros during reset and an aborted transfer leaves no trace.
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_dat_o = rdat_q;
  assign m_ack_o = ack_q;
  assign m_err_o = err_q;

  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_sel_o = sel_q;
  assign s_we_o  = we_q;
  assign s_cyc_o = (state_q == ST_WAIT);
  assign s_stb_o = s_cyc_o ? (4'b0001 << idx_q) : 4'b0000;

endmodule
